// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the five-stage Y86 core: per-stage stall/bubble
// decisions, a run/drain/halt status machine and free-running performance counters.
module pipe_ctrl #(
    parameter int RET_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       dec_icode,
    input  logic [7:0]       dec_srcA,
    input  logic [7:0]       dec_srcB,
    input  logic [7:0]       ex_icode,
    input  logic [7:0]       ex_dstM,
    input  logic             ex_Cnd,
    input  logic [7:0]       mem_stat,
    input  logic [7:0]       wb_icode,
    input  logic [7:0]       wb_stat,
    output logic             fetch_stall,
    output logic             dec_stall,
    output logic             dec_bubble,
    output logic             ex_bubble,
    output logic             mem_bubble,
    output logic             wb_stall,
    output logic             set_cc,
    output logic [7:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_retired,
    output logic [CNT_W-1:0] perf_bubbles
);

    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [7:0] IC_NOP    = 8'h01;
    localparam logic [7:0] IC_OPL    = 8'h06;
    localparam logic [7:0] IC_JXX    = 8'h07;
    localparam logic [7:0] IC_MRMOVL = 8'h05;
    localparam logic [7:0] IC_POPL   = 8'h0B;
    localparam logic [7:0] REG_NONE  = 8'h0F;
    localparam logic [7:0] STAT_AOK  = 8'h01;
    localparam logic [2:0] RET_LOAD  = 3'(RET_LAT - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ret_cnt;
    logic [7:0]       r_cpu_stat;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_bubbles;

    logic w_dec_ret;
    logic w_load_use;
    logic w_mispredict;
    logic w_ret_active;
    logic w_ret_load;
    logic w_mem_ok;
    logic w_wb_ok;

    logic w_fetch_stall;
    logic w_dec_stall;
    logic w_dec_bubble;
    logic w_ex_bubble;
    logic w_mem_bubble;
    logic w_wb_stall;
    logic w_set_cc;

    assign w_dec_ret    = (dec_icode[3:0] == IC_RET);
    assign w_load_use   = ((ex_icode == IC_MRMOVL) || (ex_icode == IC_POPL)) &&
                          (ex_dstM != REG_NONE) &&
                          ((ex_dstM == dec_srcA) || (ex_dstM == dec_srcB));
    assign w_mispredict = (ex_icode == IC_JXX) && !ex_Cnd;
    assign w_ret_active = w_dec_ret || (r_ret_cnt != 3'd0);
    // A ret that is being squashed or held in decode must not start the countdown.
    assign w_ret_load   = w_dec_ret && (r_ret_cnt == 3'd0) && !w_load_use && !w_mispredict;
    assign w_mem_ok     = (mem_stat == STAT_AOK);
    assign w_wb_ok      = (wb_stat == STAT_AOK);

    always_comb begin
        w_fetch_stall = 1'b0;
        w_dec_stall   = 1'b0;
        w_dec_bubble  = 1'b0;
        w_ex_bubble   = 1'b0;
        w_mem_bubble  = 1'b0;
        w_wb_stall    = 1'b0;
        w_set_cc      = 1'b0;
        if (rst) begin
            w_dec_bubble = 1'b1;
            w_ex_bubble  = 1'b1;
            w_mem_bubble = 1'b1;
        end else if (r_state == S_HALTED) begin
            w_fetch_stall = 1'b1;
            w_dec_stall   = 1'b1;
            w_wb_stall    = 1'b1;
        end else begin
            w_fetch_stall = w_load_use || w_ret_active;
            w_dec_stall   = w_load_use;
            w_dec_bubble  = w_mispredict || (w_ret_active && !w_load_use);
            w_ex_bubble   = w_mispredict || w_load_use;
            w_mem_bubble  = !w_mem_ok || !w_wb_ok;
            w_wb_stall    = !w_wb_ok;
            w_set_cc      = (ex_icode == IC_OPL) && w_mem_ok && w_wb_ok && (r_state == S_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_ret_cnt  <= 3'd0;
            r_cpu_stat <= STAT_AOK;
            r_halted   <= 1'b0;
            r_cycles   <= '0;
            r_retired  <= '0;
            r_bubbles  <= '0;
        end else if (r_state != S_HALTED) begin
            r_cycles <= r_cycles + CNT_W'(1);
            if (w_wb_ok && (wb_icode != IC_NOP))
                r_retired <= r_retired + CNT_W'(1);
            if (w_dec_bubble || w_ex_bubble)
                r_bubbles <= r_bubbles + CNT_W'(1);

            if (w_ret_load)
                r_ret_cnt <= RET_LOAD;
            else if (r_ret_cnt != 3'd0)
                r_ret_cnt <= r_ret_cnt - 3'd1;

            // The first faulting instruction to reach write-back freezes the machine.
            if (!w_wb_ok) begin
                r_state    <= S_HALTED;
                r_cpu_stat <= wb_stat;
                r_halted   <= 1'b1;
            end else if (r_state == S_RUN && !w_mem_ok) begin
                r_state <= S_DRAIN;
            end
        end
    end

    assign fetch_stall  = w_fetch_stall;
    assign dec_stall    = w_dec_stall;
    assign dec_bubble   = w_dec_bubble;
    assign ex_bubble    = w_ex_bubble;
    assign mem_bubble   = w_mem_bubble;
    assign wb_stall     = w_wb_stall;
    assign set_cc       = w_set_cc;
    assign cpu_stat     = r_cpu_stat;
    assign halted       = r_halted;
    assign perf_cycles  = r_cycles;
    assign perf_retired = r_retired;
    assign perf_bubbles = r_bubbles;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86 core. It is the controller for the inter-stage registers (fetch, decode, execute, memory, write-back). Each cycle it decides stall/bubble for every stage and handles load-use, mispredicted jumps and `ret`. It also runs a run/drain/halt status FSM that freezes the machine on the first exception and keeps cycle, retire and bubble performance counters.

## Interface
- RET_LAT, default 3: total fetch-stall cycles per `ret`, counted from the cycle `ret` is in decode; legal range 1..7.
- CNT_W, default 32: performance counter width.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dec_icode  in  8  icode in decode (low nibble significant)
- dec_srcA  in  8  decode source A register id; 8'h0F = none
- dec_srcB  in  8  decode source B register id; 8'h0F = none
- ex_icode  in  8  icode in execute
- ex_dstM  in  8  execute-stage memory destination register; 8'h0F = none
- ex_Cnd  in  1  branch condition computed in execute
- mem_stat  in  8  status of instruction in memory stage
- wb_icode  in  8  icode in write-back
- wb_stat  in  8  status of instruction in write-back
- fetch_stall  out  1  hold fetch PC register
- dec_stall  out  1  hold decode register
- dec_bubble  out  1  load NOP into decode register
- ex_bubble  out  1  load NOP into execute register
- mem_bubble  out  1  load NOP into memory register
- wb_stall  out  1  hold write-back register
- set_cc  out  1  condition-code write enable
- cpu_stat  out  8  machine status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- halted  out  1  FSM in HALTED
- perf_cycles, perf_retired, perf_bubbles  out  CNT_W each  performance counters

## Operation
- Icodes: HALT 0, NOP 1, OPL 6, JXX 7, RET 9, MRMOVL 5, POPL B. Status AOK = 8'h01.
- load_use = ex_icode in {MRMOVL, POPL} && ex_dstM != 8'h0F && ex_dstM in {dec_srcA, dec_srcB}.
- mispredict = ex_icode == JXX && !ex_Cnd.
- ret_cnt register (3 bits).
- ret_active = (dec_icode == RET) || ret_cnt != 0.
- When dec_icode == RET && ret_cnt == 0 && !load_use && !mispredict, load ret_cnt = RET_LAT-1.
- Otherwise, a nonzero ret_cnt decrements by 1 each cycle.
- A `ret` squashed by mispredict, or held by load_use, never loads the counter.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when mem_stat != AOK && wb_stat == AOK.
  - RUN or DRAIN -> HALTED when wb_stat != AOK; on that edge cpu_stat latches wb_stat.
  - DRAIN stays in DRAIN until wb_stat != AOK.
  - HALTED is left only by rst.
- RUN/DRAIN outputs:
  - fetch_stall = load_use || ret_active
  - dec_stall = load_use
  - dec_bubble = mispredict || (ret_active && !load_use)
  - ex_bubble = mispredict || load_use
  - mem_bubble = mem_stat != AOK || wb_stat != AOK
  - wb_stall = wb_stat != AOK
  - set_cc = ex_icode == OPL && mem_stat == AOK && wb_stat == AOK && state == RUN
- HALTED outputs:
  - fetch_stall = dec_stall = wb_stall = 1; all bubbles 0; set_cc 0.
  - ret_cnt frozen.
- Counters:
  - perf_cycles +1 every cycle not HALTED.
  - perf_retired +1 when wb_stat == AOK && wb_icode != NOP and not HALTED.
  - perf_bubbles +1 when (dec_bubble || ex_bubble) and not HALTED.
  - All counters wrap modulo 2^CNT_W and freeze in HALTED.

## Timing
- Stall, bubble and set_cc outputs are combinational from the inputs and current state, valid in the same cycle.
- ret_cnt, FSM state, cpu_stat and counters are registered, updated on the rising edge.
- Reset values:
  - Registered: state RUN, ret_cnt 0, cpu_stat 8'h01, halted 0, all counters 0.
  - While rst = 1 (overrides all else): dec_bubble = ex_bubble = mem_bubble = 1; fetch_stall = dec_stall = wb_stall = set_cc = 0.
- `ret` latency: fetch_stall high for exactly RET_LAT consecutive cycles (1 combinational + RET_LAT-1 counted), absent other hazards.
- Simultaneous hazards:
  - load_use with `ret` in decode: stall wins, no dec_bubble, counter not loaded.
  - mispredict with `ret` in decode: both bubbles asserted, counter not loaded.
- rst mid-`ret` or mid-DRAIN clears ret_cnt and FSM on the next edge.

## Test plan
- Reset then NOPs, wb_stat = 1: all outputs 0, perf_cycles = 10 after 10 cycles, perf_retired = 0.
- ex_icode = 5, ex_dstM = 2, dec_srcA = 2: fetch_stall = dec_stall = ex_bubble = 1, dec_bubble = 0, for one cycle. Repeat with dec_srcA = 8'h0F: no stall.
- dec_icode = 9 for one cycle, then NOP: fetch_stall and dec_bubble high exactly 3 cycles, perf_bubbles += 3.
- ex_icode = 7, ex_Cnd = 0, with dec_icode = 9: dec_bubble = ex_bubble = 1 for 1 cycle, fetch_stall 1 cycle only.
- mem_stat = 3, then wb_stat = 3 next cycle: DRAIN for 1 cycle with mem_bubble = 1 and set_cc = 0 for ex_icode = 6; then halted = 1, cpu_stat = 3, counters frozen across 20 cycles.
- HALTED, then rst for 1 cycle: cpu_stat = 1, halted = 0, counters 0.
